// File: rtl/reg_file_write_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file.
// The master side is the requester/register-file side; the arbiter takes the slave modport.
interface reg_file_write_arbiter_if #(
    parameter int SEL_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  in_alu_valid;
    logic [SEL_WIDTH-1:0]  in_alu_sel;
    logic [DATA_WIDTH-1:0] in_alu_data;
    logic                  out_alu_ready;

    logic                  in_mem_valid;
    logic [SEL_WIDTH-1:0]  in_mem_sel;
    logic [DATA_WIDTH-1:0] in_mem_data;
    logic                  out_mem_ready;

    logic                  out_write_en;
    logic [SEL_WIDTH-1:0]  out_write_sel;
    logic [DATA_WIDTH-1:0] out_write_data;

    modport master (
        output in_alu_valid, in_alu_sel, in_alu_data,
        output in_mem_valid, in_mem_sel, in_mem_data,
        input  out_alu_ready, out_mem_ready,
        input  out_write_en, out_write_sel, out_write_data
    );

    modport slave (
        input  in_alu_valid, in_alu_sel, in_alu_data,
        input  in_mem_valid, in_mem_sel, in_mem_data,
        output out_alu_ready, out_mem_ready,
        output out_write_en, out_write_sel, out_write_data
    );
endinterface

// File: rtl/reg_file_write_arbiter.sv
// Shares the register file write port between the ALU and memory writeback paths
// and tracks registers whose long-latency result is still outstanding.
module reg_file_write_arbiter #(
    parameter int NUM_REGS   = 16,
    parameter int SEL_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_file_write_arbiter_if.slave bus,
    input  logic                 in_reserve_en,
    input  logic [SEL_WIDTH-1:0] in_reserve_sel,
    input  logic [SEL_WIDTH-1:0] in_query_sel_ra,
    input  logic [SEL_WIDTH-1:0] in_query_sel_rb,
    input  logic [SEL_WIDTH-1:0] in_query_sel_rc,
    output logic                 out_busy_ra,
    output logic                 out_busy_rb,
    output logic                 out_busy_rc,
    output logic [NUM_REGS-1:0]  out_busy_vec
);

    logic                  alu_grant;
    logic                  mem_grant;
    logic                  last_grant_mem;
    logic [NUM_REGS-1:0]   busy_vec;
    logic [NUM_REGS-1:0]   busy_next;
    logic                  write_en;
    logic [SEL_WIDTH-1:0]  write_sel;
    logic [DATA_WIDTH-1:0] write_data;

    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (bus.in_alu_valid && bus.in_mem_valid) begin
            alu_grant = last_grant_mem;
            mem_grant = !last_grant_mem;
        end else begin
            alu_grant = bus.in_alu_valid;
            mem_grant = bus.in_mem_valid;
        end
    end

    // Reserve is applied after the clear so it wins on a same-register collision.
    always_comb begin
        busy_next = busy_vec;
        if (mem_grant)
            busy_next[bus.in_mem_sel] = 1'b0;
        if (in_reserve_en)
            busy_next[in_reserve_sel] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_mem <= 1'b1;
            busy_vec       <= '0;
            write_en       <= 1'b0;
            write_sel      <= '0;
            write_data     <= '0;
        end else begin
            busy_vec <= busy_next;
            if (bus.in_alu_valid && bus.in_mem_valid)
                last_grant_mem <= mem_grant;
            if (alu_grant) begin
                write_en   <= (bus.in_alu_sel != '0);
                write_sel  <= bus.in_alu_sel;
                write_data <= bus.in_alu_data;
            end else if (mem_grant) begin
                write_en   <= (bus.in_mem_sel != '0);
                write_sel  <= bus.in_mem_sel;
                write_data <= bus.in_mem_data;
            end else begin
                write_en   <= 1'b0;
            end
        end
    end

    assign bus.out_alu_ready  = alu_grant;
    assign bus.out_mem_ready  = mem_grant;
    assign bus.out_write_en   = write_en;
    assign bus.out_write_sel  = write_sel;
    assign bus.out_write_data = write_data;
    assign out_busy_vec       = busy_vec;

    // A register stays busy while its final write is still registered toward the file.
    assign out_busy_ra = (in_query_sel_ra != '0) &&
                         (busy_vec[in_query_sel_ra] || (write_en && write_sel == in_query_sel_ra));
    assign out_busy_rb = (in_query_sel_rb != '0) &&
                         (busy_vec[in_query_sel_rb] || (write_en && write_sel == in_query_sel_rb));
    assign out_busy_rc = (in_query_sel_rc != '0) &&
                         (busy_vec[in_query_sel_rc] || (write_en && write_sel == in_query_sel_rc));

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Directed bench for reg_file_write_arbiter: arbitration, write latency, scoreboard and reset.
module tb_reg_file_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_reserve_en;
    logic [3:0]  in_reserve_sel;
    logic [3:0]  in_query_sel_ra;
    logic [3:0]  in_query_sel_rb;
    logic [3:0]  in_query_sel_rc;
    logic        out_busy_ra;
    logic        out_busy_rb;
    logic        out_busy_rc;
    logic [15:0] out_busy_vec;

    int total = 0;
    int bad   = 0;

    reg_file_write_arbiter_if #(.SEL_WIDTH(4), .DATA_WIDTH(32)) bus ();

    reg_file_write_arbiter #(.NUM_REGS(16), .SEL_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .in_reserve_en   (in_reserve_en),
        .in_reserve_sel  (in_reserve_sel),
        .in_query_sel_ra (in_query_sel_ra),
        .in_query_sel_rb (in_query_sel_rb),
        .in_query_sel_rc (in_query_sel_rc),
        .out_busy_ra     (out_busy_ra),
        .out_busy_rb     (out_busy_rb),
        .out_busy_rc     (out_busy_rc),
        .out_busy_vec    (out_busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic en, input logic [3:0] sel,
                             input logic [31:0] data);
        chk({tag, "_en"}, {31'b0, bus.out_write_en}, {31'b0, en});
        if (en) begin
            chk({tag, "_sel"},  {28'b0, bus.out_write_sel}, {28'b0, sel});
            chk({tag, "_data"}, bus.out_write_data, data);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_reserve_en = 1'b0; in_reserve_sel = 4'd0;
        in_query_sel_ra = 4'd7; in_query_sel_rb = 4'd9; in_query_sel_rc = 4'd0;
        bus.in_alu_valid = 1'b0; bus.in_alu_sel = 4'd0; bus.in_alu_data = 32'h0;
        bus.in_mem_valid = 1'b0; bus.in_mem_sel = 4'd0; bus.in_mem_data = 32'h0;

        // Reset then idle
        step(); step();
        rst_n = 1'b1;
        chk_write("rst", 1'b0, 4'd0, 32'h0);
        chk("rst_sel",  {28'b0, bus.out_write_sel}, 32'h0);
        chk("rst_data", bus.out_write_data, 32'h0);
        chk("rst_vec", {16'b0, out_busy_vec}, 32'h0);
        chk("rst_busy", {29'b0, out_busy_ra, out_busy_rb, out_busy_rc}, 32'h0);
        step();
        chk_write("idle", 1'b0, 4'd0, 32'h0);

        // Single ALU write
        bus.in_alu_valid = 1'b1; bus.in_alu_sel = 4'd5; bus.in_alu_data = 32'hDEADBEEF;
        #1;
        chk("alu1_ready", {31'b0, bus.out_alu_ready}, 32'h1);
        chk("alu1_mready", {31'b0, bus.out_mem_ready}, 32'h0);
        step();
        bus.in_alu_valid = 1'b0;
        chk_write("alu1_wr", 1'b1, 4'd5, 32'hDEADBEEF);
        step();
        chk_write("alu1_idle", 1'b0, 4'd0, 32'h0);
        chk("alu1_hold_sel",  {28'b0, bus.out_write_sel}, 32'h5);
        chk("alu1_hold_data", bus.out_write_data, 32'hDEADBEEF);

        // Contention: first tie goes to ALU
        bus.in_alu_valid = 1'b1; bus.in_alu_sel = 4'd1; bus.in_alu_data = 32'h11;
        bus.in_mem_valid = 1'b1; bus.in_mem_sel = 4'd2; bus.in_mem_data = 32'h22;
        #1;
        chk("tie1_alu", {31'b0, bus.out_alu_ready}, 32'h1);
        chk("tie1_mem", {31'b0, bus.out_mem_ready}, 32'h0);
        step();
        bus.in_alu_valid = 1'b0;
        #1;
        chk_write("tie1_wr1", 1'b1, 4'd1, 32'h11);
        chk("tie1_mem2", {31'b0, bus.out_mem_ready}, 32'h1);
        step();
        bus.in_mem_valid = 1'b0;
        chk_write("tie1_wr2", 1'b1, 4'd2, 32'h22);

        // Second tie round goes to MEM
        bus.in_alu_valid = 1'b1; bus.in_alu_sel = 4'd3; bus.in_alu_data = 32'h33;
        bus.in_mem_valid = 1'b1; bus.in_mem_sel = 4'd4; bus.in_mem_data = 32'h44;
        #1;
        chk("tie2_alu", {31'b0, bus.out_alu_ready}, 32'h0);
        chk("tie2_mem", {31'b0, bus.out_mem_ready}, 32'h1);
        step();
        bus.in_mem_valid = 1'b0;
        #1;
        chk_write("tie2_wr1", 1'b1, 4'd4, 32'h44);
        chk("tie2_alu2", {31'b0, bus.out_alu_ready}, 32'h1);
        step();
        bus.in_alu_valid = 1'b0;
        chk_write("tie2_wr2", 1'b1, 4'd3, 32'h33);
        step();
        chk_write("tie2_idle", 1'b0, 4'd0, 32'h0);

        // Scoreboard lifecycle on r7
        in_reserve_en = 1'b1; in_reserve_sel = 4'd7;
        #1;
        chk("sb7_pre", {31'b0, out_busy_ra}, 32'h0);
        step();
        in_reserve_en = 1'b0;
        chk("sb7_vec1", {16'b0, out_busy_vec}, 32'h0080);
        chk("sb7_busy1", {31'b0, out_busy_ra}, 32'h1);
        step(); step();
        chk("sb7_vec3", {16'b0, out_busy_vec}, 32'h0080);
        bus.in_mem_valid = 1'b1; bus.in_mem_sel = 4'd7; bus.in_mem_data = 32'h77;
        #1;
        chk("sb7_mready", {31'b0, bus.out_mem_ready}, 32'h1);
        step();
        bus.in_mem_valid = 1'b0;
        chk_write("sb7_wr", 1'b1, 4'd7, 32'h77);
        chk("sb7_vec_clr", {16'b0, out_busy_vec}, 32'h0);
        chk("sb7_busy_inflight", {31'b0, out_busy_ra}, 32'h1);
        step();
        chk("sb7_busy_done", {31'b0, out_busy_ra}, 32'h0);

        // Same-cycle reserve and clear on r9: reserve wins
        in_reserve_en = 1'b1; in_reserve_sel = 4'd9;
        step();
        chk("sb9_set", {16'b0, out_busy_vec}, 32'h0200);
        bus.in_mem_valid = 1'b1; bus.in_mem_sel = 4'd9; bus.in_mem_data = 32'h99;
        step();
        in_reserve_en = 1'b0;
        chk("sb9_collide", {16'b0, out_busy_vec}, 32'h0200);
        chk_write("sb9_wr", 1'b1, 4'd9, 32'h99);
        chk("sb9_busy", {31'b0, out_busy_rb}, 32'h1);
        step();
        bus.in_mem_valid = 1'b0;
        chk("sb9_clr", {16'b0, out_busy_vec}, 32'h0);

        // r0: reserve ignored, ALU write handshakes but does not write
        in_reserve_en = 1'b1; in_reserve_sel = 4'd0;
        bus.in_alu_valid = 1'b1; bus.in_alu_sel = 4'd0; bus.in_alu_data = 32'h1234;
        #1;
        chk("r0_ready", {31'b0, bus.out_alu_ready}, 32'h1);
        step();
        in_reserve_en = 1'b0; bus.in_alu_valid = 1'b0;
        chk_write("r0_wr", 1'b0, 4'd0, 32'h0);
        chk("r0_vec", {16'b0, out_busy_vec}, 32'h0);
        chk("r0_busy", {31'b0, out_busy_rc}, 32'h0);

        // Reset mid-operation
        in_reserve_en = 1'b1; in_reserve_sel = 4'd3;
        step();
        in_reserve_sel = 4'd4;
        step();
        in_reserve_en = 1'b0;
        chk("mid_vec", {16'b0, out_busy_vec}, 32'h0018);
        bus.in_alu_valid = 1'b1; bus.in_alu_sel = 4'd10; bus.in_alu_data = 32'hAA;
        bus.in_mem_valid = 1'b1; bus.in_mem_sel = 4'd5;  bus.in_mem_data = 32'h55;
        #1;
        chk("mid_tie_alu", {31'b0, bus.out_alu_ready}, 32'h1);
        step();
        bus.in_alu_valid = 1'b0;
        #1;
        chk("mid_mready", {31'b0, bus.out_mem_ready}, 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_vec", {16'b0, out_busy_vec}, 32'h0);
        chk("mid_rst_en", {31'b0, bus.out_write_en}, 32'h0);
        // Pointer back to MEM, so ALU wins this tie again
        bus.in_alu_valid = 1'b1;
        #1;
        chk("mid_rst_tie", {31'b0, bus.out_alu_ready}, 32'h1);
        step();
        bus.in_alu_valid = 1'b0; bus.in_mem_valid = 1'b0;
        chk_write("mid_rst_wr", 1'b1, 4'd10, 32'hAA);
        step();
        chk_write("mid_end", 1'b0, 4'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
